mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch port (I, read-only) and data port (D, load/store). The arbiter grants one requester at a time and drives the downstream valid/ready request and response handshake. It returns data with a registered done pulse. Sits between the pipeline's IF/MEM stages and the unified memory; the pipeline's hazard logic stalls on a pending, not-yet-done request.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive D grants while I waits before I is forced to win (1..15)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
i_req  input  1  fetch request; held until i_done or withdrawn
i_addr  input  ADDR_W  fetch address
i_kill  input  1  discard in-flight fetch (branch redirect/flush)
i_done  output  1  one-cycle pulse: i_rdata valid
i_rdata  output  DATA_W  fetched word
d_req  input  1  data request; held until d_done
d_write  input  1  1 = store, 0 = load
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_done  output  1  one-cycle pulse: load data valid / store complete
d_rdata  output  DATA_W  load data
mem_valid  output  1  downstream request valid
mem_ready  input  1  downstream accepts request
mem_write  output  1  downstream write strobe
mem_addr  output  ADDR_W  downstream address
mem_wdata  output  DATA_W  downstream write data
mem_resp_valid  input  1  downstream response (reads and writes both respond)
mem_rdata  input  DATA_W  downstream read data

Behaviour:
- Reset: state IDLE; mem_valid, mem_write, i_done, d_done = 0; i_rdata, d_rdata, mem_addr, mem_wdata = 0; starve_cnt = 0; owner = none; kill_pending = 0. Reset mid-transaction abandons it silently; the downstream memory is reset together with the arbiter.
- FSM with three states:
  - IDLE: if any request is present, latch owner, addr, write and wdata into registers, then go to ISSUE.
  - ISSUE: mem_valid = 1 with the latched fields, held stable until mem_ready. When mem_valid and mem_ready are both high, go to WAIT.
  - WAIT: on mem_resp_valid, register rdata into the owner's rdata output, pulse the owner's done for exactly 1 cycle (the cycle after mem_resp_valid), then return to IDLE. A new grant can be evaluated in that same done cycle.
- Minimum latency: req sampled at cycle N → mem_valid at N+1 → ready at N+1 → resp at N+2 → done at N+3.
- mem_resp_valid while in IDLE or ISSUE is ignored.
- Grant priority in IDLE: D wins over I, with one exception. If I has been waiting and starve_cnt == STARVE_LIMIT, I wins.
- starve_cnt rules:
  - increments, saturating at STARVE_LIMIT, on each D grant made while i_req = 1;
  - clears on any I grant;
  - clears when i_req is low in IDLE.
- Requests are sampled only in IDLE. Deasserting a req before its grant produces no transaction.
- Inputs are latched at grant, so later changes to addr/wdata do not affect an in-flight transaction.
- i_kill:
  - With I granted and in ISSUE or WAIT: set kill_pending. The memory transaction still completes, but i_done is suppressed and i_rdata is left unchanged.
  - In IDLE: i_kill blocks an I grant in that cycle.
  - With D as owner: no effect.
- i_done and d_done are never high in the same cycle. Each done pulse lasts exactly one cycle.
- rdata outputs hold their last value between done pulses.

Decomposition:
- Shared package:
  - state encoding (IDLE = 0, ISSUE = 1, WAIT = 2);
  - owner encoding (OWN_I, OWN_D);
  - ADDR_W/DATA_W defaults reused by the CPU top.
- One sub-module is natural: `starve_counter`, a saturating counter with inc/clr and an at_limit flag.
- Rest is a single FSM plus latched request registers.

Test Plan:
1. Read timing: I only, i_addr = 0x40, mem_ready tied 1, resp 1 cycle after accept with rdata = 0x00500093 → i_done pulse at cycle N+3, i_rdata = 0x00500093, mem_write = 0.
2. Same-cycle collision: I and D in the same IDLE cycle, D store addr 0x100, wdata 0xDEADBEEF → D served first (mem_write = 1, mem_wdata = 0xDEADBEEF), d_done fires, then I served next; no done overlap.
3. Starvation guard: i_req held, d_req reasserted after every d_done, STARVE_LIMIT = 4 → exactly 4 D transactions, then I is granted on the 5th arbitration; starve_cnt returns to 0.
4. Backpressure: mem_ready low for 3 cycles during ISSUE → mem_valid, mem_addr and mem_wdata stay stable for all 3 cycles; single accept; d_done once.
5. Kill: i_kill pulses while I is in WAIT → no i_done and i_rdata unchanged; the FSM still returns to IDLE after mem_resp_valid; the following D request is served normally.
6. Reset mid-operation: reset during WAIT → next cycle all outputs are 0 and state is IDLE; a stray mem_resp_valid after reset produces no done.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int STARVE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of D grants made while a fetch was waiting.
module starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  logic [STARVE_W-1:0] count;

  // Clear wins over increment; increment stops at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_limit) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count == STARVE_W'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch (I) and data (D) ports onto one variable-latency memory.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no transaction; requests are sampled and a winner is latched
// ST_ISSUE | mem_valid high with latched fields, waiting for mem_ready
// ST_WAIT  | request accepted, waiting for mem_resp_valid
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_kill,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state, state_n;
  owner_t            owner;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic              kill_pending;
  logic              grant_i, grant_d;
  logic              at_limit;
  logic              i_ok;
  logic              resp_done;

  // A killed-in-IDLE fetch must not be granted this cycle.
  assign i_ok      = i_req && !i_kill;
  assign resp_done = (state == ST_WAIT) && mem_resp_valid;

  starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc      (grant_d && i_req),
    .clr      (grant_i || ((state == ST_IDLE) && !i_req)),
    .at_limit (at_limit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next state and grant decision: D first unless the fetch has starved.
  always_comb begin
    state_n = state;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_ok && (at_limit || !d_req)) begin
          grant_i = 1'b1;
          state_n = ST_ISSUE;
        end else if (d_req) begin
          grant_d = 1'b1;
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: if (mem_ready)      state_n = ST_WAIT;
      ST_WAIT:  if (mem_resp_valid) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Latched request fields, kill tracking and registered done/rdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner        <= OWN_NONE;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      kill_pending <= 1'b0;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;

      if (grant_i) begin
        owner        <= OWN_I;
        addr_q       <= i_addr;
        write_q      <= 1'b0;
        wdata_q      <= '0;
        kill_pending <= 1'b0;
      end else if (grant_d) begin
        owner        <= OWN_D;
        addr_q       <= d_addr;
        write_q      <= d_write;
        wdata_q      <= d_wdata;
        kill_pending <= 1'b0;
      end

      if ((state != ST_IDLE) && (owner == OWN_I) && i_kill) begin
        kill_pending <= 1'b1;
      end

      // A kill arriving in the same cycle as the response also suppresses it.
      if (resp_done) begin
        if (owner == OWN_D) begin
          d_done  <= 1'b1;
          d_rdata <= mem_rdata;
        end else if ((owner == OWN_I) && !(kill_pending || i_kill)) begin
          i_done  <= 1'b1;
          i_rdata <= mem_rdata;
        end
        owner        <= OWN_NONE;
        kill_pending <= 1'b0;
      end
    end
  end

  assign mem_valid = (state == ST_ISSUE);
  assign mem_write = (state == ST_ISSUE) && write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios push expected
// memory requests and done responses; the responder and monitor check them.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_kill, i_done;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_write, d_done;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_valid, mem_ready, mem_write, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  typedef struct packed { logic is_d; logic [31:0] data; logic chk_data; } done_t;
  typedef struct packed { logic wr; logic [31:0] addr; logic [31:0] wdata; } mtx_t;

  done_t exp_done[$];
  mtx_t  exp_mem[$];
  int    checks = 0;
  int    errors = 0;
  int    stall_cfg = 0;
  int    resp_delay = 0;
  logic [31:0] mem_model [logic [31:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[15:0], 16'hC0DE};
  endfunction

  task automatic push_mem(input logic wr, input logic [31:0] a, input logic [31:0] wd);
    mtx_t t;
    t.wr = wr; t.addr = a; t.wdata = wd;
    exp_mem.push_back(t);
  endtask

  task automatic push_done(input logic is_d, input logic [31:0] data, input logic chk_data);
    done_t t;
    t.is_d = is_d; t.data = data; t.chk_data = chk_data;
    exp_done.push_back(t);
  endtask

  // Downstream memory: optional backpressure, configurable response delay.
  initial begin
    int   stall_left = 0;
    int   resp_cnt = 0;
    bit   armed = 0;
    bit   stab_valid = 0;
    logic [31:0] p_addr = '0, p_wd = '0, stab_addr = '0, stab_wdata = '0;
    logic p_wr = 1'b0;
    mtx_t e;
    mem_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_rdata = '0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_resp_valid = 1'b1;
          if (p_wr) mem_model[p_addr] = p_wd;
          else      mem_rdata = rd(p_addr);
        end
      end
      mem_ready = 1'b0;
      if (stab_valid) begin
        chk("hold_valid", {31'b0, mem_valid}, 32'd1);
        chk("hold_addr", mem_addr, stab_addr);
        chk("hold_wdata", mem_wdata, stab_wdata);
        stab_valid = 0;
      end
      if (mem_valid) begin
        if (!armed) begin armed = 1; stall_left = stall_cfg; end
        if (stall_left > 0) begin
          stall_left--;
          stab_valid = 1; stab_addr = mem_addr; stab_wdata = mem_wdata;
        end else begin
          mem_ready = 1'b1;
          armed = 0;
          p_addr = mem_addr; p_wr = mem_write; p_wd = mem_wdata;
          resp_cnt = 1 + resp_delay;
          if (exp_mem.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_mem_req: got addr %h wr %0d expected none", mem_addr, mem_write);
          end else begin
            e = exp_mem.pop_front();
            chk("mem_write", {31'b0, mem_write}, {31'b0, e.wr});
            chk("mem_addr", mem_addr, e.addr);
            if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
          end
        end
      end
    end
  end

  // Done monitor: every done pulse must match the next expected response.
  initial begin
    done_t e;
    forever begin
      @(negedge clk);
      if (i_done || d_done) chk("done_overlap", {31'b0, i_done && d_done}, 32'd0);
      if (i_done || d_done) begin
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got i_done=%0d d_done=%0d expected none", i_done, d_done);
        end else begin
          e = exp_done.pop_front();
          chk("done_port", {31'b0, d_done}, {31'b0, e.is_d});
          if (e.chk_data) chk("done_data", e.is_d ? d_rdata : i_rdata, e.data);
        end
      end
    end
  end

  // Serve outstanding requests, dropping each one when its done is seen.
  task automatic run_until(input string name, input int limit);
    int n = 0;
    while ((i_req || d_req) && n < limit) begin
      @(negedge clk);
      if (i_done) i_req = 1'b0;
      if (d_done) d_req = 1'b0;
      n++;
    end
    if (i_req || d_req) begin
      chk(name, 32'd1, 32'd0);
      i_req = 1'b0; d_req = 1'b0;
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!mem_valid && n < 50);
    if (!mem_valid) chk(name, 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_valid"}, {31'b0, mem_valid}, 32'd0);
    chk({tag, "_mem_write"}, {31'b0, mem_write}, 32'd0);
    chk({tag, "_dones"}, {30'b0, i_done, d_done}, 32'd0);
    chk({tag, "_i_rdata"}, i_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    int n_d;
    int n;
    reset = 1'b1; i_req = 0; i_addr = '0; i_kill = 0;
    d_req = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    mem_model[32'h40] = 32'h0050_0093;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // 1: fetch-only timing, done three cycles after the sampling edge
    i_req = 1'b1; i_addr = 32'h40;
    push_mem(1'b0, 32'h40, '0);
    push_done(1'b0, 32'h0050_0093, 1'b1);
    @(negedge clk);
    chk("t1_valid", {31'b0, mem_valid}, 32'd1);
    chk("t1_write", {31'b0, mem_write}, 32'd0);
    chk("t1_addr", mem_addr, 32'h40);
    @(negedge clk);
    chk("t1_wait_valid", {31'b0, mem_valid}, 32'd0);
    @(negedge clk);
    chk("t1_i_done", {31'b0, i_done}, 32'd1);
    i_req = 1'b0;
    repeat (2) @(negedge clk);

    // 2: simultaneous I and D; the store goes first
    i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    push_mem(1'b1, 32'h100, 32'hDEAD_BEEF);
    push_mem(1'b0, 32'h40, '0);
    push_done(1'b1, '0, 1'b0);
    push_done(1'b0, 32'h0050_0093, 1'b1);
    run_until("t2_timeout", 40);
    d_write = 1'b0;
    repeat (2) @(negedge clk);

    // 3: fetch held while D keeps re-requesting: four D grants, then I
    i_req = 1'b1; i_addr = 32'h80;
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h200;
    push_mem(1'b0, 32'h200, '0); push_mem(1'b0, 32'h204, '0);
    push_mem(1'b0, 32'h208, '0); push_mem(1'b0, 32'h20C, '0);
    push_mem(1'b0, 32'h80, '0);  push_mem(1'b0, 32'h210, '0);
    push_done(1'b1, 32'h0200_C0DE, 1'b1); push_done(1'b1, 32'h0204_C0DE, 1'b1);
    push_done(1'b1, 32'h0208_C0DE, 1'b1); push_done(1'b1, 32'h020C_C0DE, 1'b1);
    push_done(1'b0, 32'h0080_C0DE, 1'b1); push_done(1'b1, 32'h0210_C0DE, 1'b1);
    n_d = 0; n = 0;
    while ((i_req || d_req) && n < 100) begin
      @(negedge clk);
      if (d_done) begin
        n_d++;
        if (n_d == 5) d_req = 1'b0;
        else          d_addr = 32'h200 + 32'(4 * n_d);
      end
      if (i_done) i_req = 1'b0;
      n++;
    end
    if (i_req || d_req) begin
      chk("t3_timeout", 32'd1, 32'd0);
      i_req = 1'b0; d_req = 1'b0;
    end
    repeat (2) @(negedge clk);

    // 4: three cycles of backpressure on a store
    stall_cfg = 3;
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h104; d_wdata = 32'h1234_5678;
    push_mem(1'b1, 32'h104, 32'h1234_5678);
    push_done(1'b1, '0, 1'b0);
    @(negedge clk);
    d_addr = 32'hFFFF_FFF0; d_wdata = 32'h0BAD_0BAD;
    run_until("t4_timeout", 40);
    stall_cfg = 0; d_write = 1'b0;
    repeat (2) @(negedge clk);

    // 5: kill a fetch while it waits for its response
    resp_delay = 2;
    i_req = 1'b1; i_addr = 32'h44;
    push_mem(1'b0, 32'h44, '0);
    wait_valid("t5_valid_timeout");
    @(negedge clk);
    chk("t5_in_wait", {31'b0, mem_valid}, 32'd0);
    i_kill = 1'b1; i_req = 1'b0;
    @(negedge clk);
    i_kill = 1'b0;
    repeat (8) @(negedge clk);
    chk("t5_i_rdata_kept", i_rdata, 32'h0080_C0DE);
    resp_delay = 0;
    d_req = 1'b1; d_addr = 32'h300;
    push_mem(1'b0, 32'h300, '0);
    push_done(1'b1, 32'h0300_C0DE, 1'b1);
    run_until("t5_timeout", 40);
    repeat (2) @(negedge clk);

    // 6: reset while waiting; the late response must be ignored
    resp_delay = 4;
    i_req = 1'b1; i_addr = 32'h48;
    push_mem(1'b0, 32'h48, '0);
    wait_valid("t6_valid_timeout");
    @(negedge clk);
    reset = 1'b1; i_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("t6");
    repeat (10) @(negedge clk);
    resp_delay = 0;
    d_req = 1'b1; d_addr = 32'h304;
    push_mem(1'b0, 32'h304, '0);
    push_done(1'b1, 32'h0304_C0DE, 1'b1);
    run_until("t6_timeout", 40);
    repeat (4) @(negedge clk);

    chk("drain_mem", exp_mem.size(), 32'd0);
    chk("drain_done", exp_done.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
